// File: rtl/uart_rx_fifo_io.sv
// Buffered UART receive FIFO exposed to the CPU as two IO words: RXDATA (read pops) and RXSTAT (status, clear/flush).
// Optional registered interrupt output enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo_io #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int IRQ_LEVEL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        sel_data,
  input  logic        sel_stat,
  input  logic        io_rstrb,
  input  logic        io_wstrb,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        overrun
`ifdef UART_RX_FIFO_IRQ_EN
  ,output logic       irq
`endif
);

  logic [7:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nx_s, wr_ptr_nx_s;
  logic [AW:0] count_r, count_nx_s;
  logic        overrun_nx_s;
  logic [31:0] rdata_nx_s;
  logic        empty_s, full_s, rd_data_s, rd_stat_s, flush_s, clr_ovr_s;
  logic        push_s, pop_s, ovr_set_s;
  logic [8:0]  cnt9_s;
  logic        unused_s;

  assign unused_s  = ^io_wdata[31:2];
  assign empty_s   = (count_r == (AW+1)'(0));
  assign full_s    = (count_r == (AW+1)'(DEPTH));
  // RXDATA wins when both selects are high
  assign rd_data_s = io_rstrb & sel_data;
  assign rd_stat_s = io_rstrb & sel_stat & ~sel_data;
  assign flush_s   = io_wstrb & sel_stat & io_wdata[1];
  assign clr_ovr_s = io_wstrb & sel_stat & io_wdata[0];
  assign pop_s     = rd_data_s & ~empty_s;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
  assign push_s    = rx_dv & ~flush_s & (~full_s | pop_s);
  assign ovr_set_s = rx_dv & ~flush_s & full_s & ~pop_s;
  assign cnt9_s    = 9'(count_r);

  // Next-state for pointers, fill count and overrun flag
  always_comb begin
    rd_ptr_nx_s  = rd_ptr_r;
    wr_ptr_nx_s  = wr_ptr_r;
    count_nx_s   = count_r;
    overrun_nx_s = overrun;
    if (flush_s) begin
      rd_ptr_nx_s = {AW{1'b0}};
      wr_ptr_nx_s = {AW{1'b0}};
      count_nx_s  = {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_nx_s = wr_ptr_r + AW'(1);
      else        wr_ptr_nx_s = wr_ptr_r;
      if (pop_s)  rd_ptr_nx_s = rd_ptr_r + AW'(1);
      else        rd_ptr_nx_s = rd_ptr_r;
      if (push_s && !pop_s)      count_nx_s = count_r + (AW+1)'(1);
      else if (pop_s && !push_s) count_nx_s = count_r - (AW+1)'(1);
      else                       count_nx_s = count_r;
    end
    if (ovr_set_s)      overrun_nx_s = 1'b1;
    else if (clr_ovr_s) overrun_nx_s = 1'b0;
    else                overrun_nx_s = overrun;
  end

  // Read data mux; holds the last value when no read strobe is present
  always_comb begin
    rdata_nx_s = io_rdata;
    if (rd_data_s) begin
      if (empty_s) rdata_nx_s = 32'h0000_0000;
      else         rdata_nx_s = {23'b0, 1'b1, mem_r[rd_ptr_r]};
    end else if (rd_stat_s) begin
      rdata_nx_s = {16'b0, cnt9_s, 4'b0, overrun, full_s, ~empty_s};
    end else begin
      rdata_nx_s = io_rdata;
    end
  end

  // Storage array write port, not reset
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= rx_byte;
  end

  // Control state and registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      overrun  <= 1'b0;
      io_rdata <= 32'h0000_0000;
    end else begin
      rd_ptr_r <= rd_ptr_nx_s;
      wr_ptr_r <= wr_ptr_nx_s;
      count_r  <= count_nx_s;
      overrun  <= overrun_nx_s;
      io_rdata <= rdata_nx_s;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  // Interrupt tracks next-state fill level so it lines up with count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (count_nx_s >= (AW+1)'(IRQ_LEVEL)) | overrun_nx_s;
  end
`else
  localparam int IRQ_LEVEL_UNUSED = IRQ_LEVEL;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_io.sv
// Directed self-checking bench for uart_rx_fifo_io (DEPTH=16); irq checks only with UART_RX_FIFO_IRQ_EN.
module tb_uart_rx_fifo_io;
  logic        clk = 1'b0;
  logic        reset, rx_dv, sel_data, sel_stat, io_rstrb, io_wstrb, overrun;
  logic [7:0]  rx_byte;
  logic [31:0] io_wdata, io_rdata, v;
`ifdef UART_RX_FIFO_IRQ_EN
  logic        irq;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  uart_rx_fifo_io #(.DEPTH(16), .AW(4), .IRQ_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .sel_data(sel_data), .sel_stat(sel_stat), .io_rstrb(io_rstrb),
    .io_wstrb(io_wstrb), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .overrun(overrun)
`ifdef UART_RX_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] stat(input int cnt, input logic ovr, input logic full, input logic av);
    logic [8:0] c;
    c = 9'(cnt);
    return {16'h0000, c, 4'h0, ovr, full, av};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    rx_dv = 1'b0; sel_data = 1'b0; sel_stat = 1'b0;
    io_rstrb = 1'b0; io_wstrb = 1'b0; io_wdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk); #1; idle();
  endtask

  task automatic push(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b; step();
  endtask

  task automatic rd_data(output logic [31:0] d);
    sel_data = 1'b1; io_rstrb = 1'b1; step(); d = io_rdata;
  endtask

  task automatic rd_stat(output logic [31:0] d);
    sel_stat = 1'b1; io_rstrb = 1'b1; step(); d = io_rdata;
  endtask

  task automatic wr_stat(input logic [31:0] d);
    sel_stat = 1'b1; io_wstrb = 1'b1; io_wdata = d; step();
  endtask

  initial begin
    idle(); rx_byte = 8'h00; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_overrun", {31'b0, overrun}, 32'h0);
    rd_stat(v); check("reset_stat", v, 32'h0);

    push(8'h41); push(8'h42);
    rd_stat(v); check("stat_two", v, stat(2, 1'b0, 1'b0, 1'b1));
    rd_data(v); check("data_41", v, 32'h0000_0141);
    rd_data(v); check("data_42", v, 32'h0000_0142);
    step(); check("rdata_hold", io_rdata, 32'h0000_0142);
    rd_stat(v); check("stat_empty", v, 32'h0);

    rd_data(v); check("data_empty", v, 32'h0);
    push(8'h55);
    rd_data(v); check("data_after_empty", v, 32'h0000_0155);

    for (int i = 0; i < 17; i++) push(8'(i));
    rd_stat(v); check("stat_overflow", v, stat(16, 1'b1, 1'b1, 1'b1));
    check("overrun_port", {31'b0, overrun}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      rd_data(v); check($sformatf("wrap_rd_%0d", i), v, 32'h100 | 32'(i));
    end
    rd_stat(v); check("stat_drained_ovr", v, stat(0, 1'b1, 1'b0, 1'b0));
    wr_stat(32'h1);
    rd_stat(v); check("stat_ovr_cleared", v, 32'h0);

    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    rx_dv = 1'b1; rx_byte = 8'hAA; sel_data = 1'b1; io_rstrb = 1'b1; step();
    check("full_pushpop_rd", io_rdata, 32'h0000_0120);
    rd_stat(v); check("full_pushpop_stat", v, stat(16, 1'b0, 1'b1, 1'b1));
    for (int i = 1; i < 16; i++) begin
      rd_data(v); check($sformatf("pp_rd_%0d", i), v, 32'h100 | 32'(8'h20 + i));
    end
    rd_data(v); check("pp_rd_aa_last", v, 32'h0000_01AA);

    for (int i = 0; i < 17; i++) push(8'h30);
    rx_dv = 1'b1; rx_byte = 8'h66; sel_stat = 1'b1; io_wstrb = 1'b1; io_wdata = 32'h1; step();
    check("ovr_set_beats_clear", {31'b0, overrun}, 32'h1);
    rx_dv = 1'b1; rx_byte = 8'h77; sel_stat = 1'b1; io_wstrb = 1'b1; io_wdata = 32'h2; step();
    rd_stat(v); check("flush_stat", v, stat(0, 1'b1, 1'b0, 1'b0));
    wr_stat(32'h1);
    push(8'h99);
    rd_data(v); check("after_flush_data", v, 32'h0000_0199);

    push(8'h5A);
    sel_data = 1'b1; sel_stat = 1'b1; io_rstrb = 1'b1; step();
    check("both_sel_data_wins", io_rdata, 32'h0000_015A);
    rd_stat(v); check("both_sel_popped", v, 32'h0);

    push(8'h11);
    sel_data = 1'b1; io_wstrb = 1'b1; io_wdata = 32'h3; step();
    rd_stat(v); check("rxdata_write_ignored", v, stat(1, 1'b0, 1'b0, 1'b1));
    rd_data(v); check("rxdata_write_data", v, 32'h0000_0111);

`ifdef UART_RX_FIFO_IRQ_EN
    check("irq_idle", {31'b0, irq}, 32'h0);
    push(8'h01);
    check("irq_first_push", {31'b0, irq}, 32'h1);
    wr_stat(32'h2);
    check("irq_after_flush", {31'b0, irq}, 32'h0);
`endif

    push(8'h12); push(8'h13);
    #2 reset = 1'b1;
    #1 check("midreset_rdata", io_rdata, 32'h0);
    check("midreset_overrun", {31'b0, overrun}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    rd_stat(v); check("midreset_stat", v, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
